puerta_ctrl_param: RTL and testbench

//  Parametrised elevator door controller; next generation of the fixed-time door FSM.

---
 rtl/puerta_ctrl_param.sv | 220 ++++++++++++++++++++++
 tb/tb_puerta_ctrl_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/puerta_ctrl_param.sv
// puerta_ctrl_param: parametrised elevator door controller.
// Door cycle CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED with manual
// open/close, obstruction reopen with a bounded retry count, and alarm hold.
// Optional feature macro: PUERTA_NUDGE_EN adds a slow-close NUDGE state that
// is taken instead of reopening once the reopen limit has been reached.
// Interface note: cycle_req is edge-sensitive (a rising edge seen in CLOSED
// starts a cycle); all other inputs are levels sampled every clock. There is
// no valid/ready handshake; done is a one-cycle completion strobe.
module puerta_ctrl_param #(
  parameter int CNT_W        = 32,
  parameter int T_TRANS      = 200_000_000,
  parameter int T_OPEN       = 600_000_000,
  parameter int T_BLINK_HALF = 25_000_000,
  parameter int MAX_REOPEN   = 3,
  parameter int T_NUDGE      = 400_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cycle_req,
  input  logic       abrir,
  input  logic       cerrar,
  input  logic       obstruccion,
  input  logic       alarma,
  output logic [1:0] estado_puerta,
  output logic       busy,
  output logic       done,
  output logic       LED_sw,
  output logic       LED_abierta,
  output logic       LED_alarma,
  output logic       fault,
  output logic [3:0] reopen_cnt
);

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING
`ifdef PUERTA_NUDGE_EN
    , ST_NUDGE
`endif
  } state_t;

  localparam logic [3:0] MAX_R = 4'(MAX_REOPEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [CNT_W-1:0] last_tick;
  logic             req_prev_q;
  logic             cyc_act_q, cyc_act_d;
  logic [3:0]       reopen_q, reopen_d;
  logic             fault_q, fault_d;
  logic [1:0]       estado_q, estado_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             led_sw_q, led_sw_d;
  logic             led_abierta_q, led_abierta_d;
  logic             led_alarma_q;
  logic             req_edge, tick, restart, entry, blink_d;

`ifndef PUERTA_NUDGE_EN
  // Without the nudge state the slow-close time has no role.
  logic unused_nudge;
  assign unused_nudge = (T_NUDGE != 0);
`endif

  // Next-state, phase timer, counters and registered-output values.
  always_comb begin
    state_d       = state_q;
    cyc_act_d     = cyc_act_q;
    reopen_d      = reopen_q;
    fault_d       = fault_q;
    done_d        = 1'b0;
    restart       = 1'b0;
    req_edge      = cycle_req & ~req_prev_q;
    last_tick     = '0;
    case (state_q)
      ST_OPENING: last_tick = CNT_W'(T_TRANS - 1);
      ST_OPEN:    last_tick = CNT_W'(T_OPEN - 1);
      ST_CLOSING: last_tick = CNT_W'(T_TRANS - 1);
`ifdef PUERTA_NUDGE_EN
      ST_NUDGE:   last_tick = CNT_W'(T_NUDGE - 1);
`endif
      default:    last_tick = '0;
    endcase
    tick = (timer_q == last_tick);

    case (state_q)
      ST_CLOSED: begin
        // A simultaneous edge and abrir still counts as a requested cycle.
        if (req_edge) begin
          state_d   = ST_OPENING;
          cyc_act_d = 1'b1;
        end else if (abrir) begin
          state_d = ST_OPENING;
        end
      end
      ST_OPENING: begin
        if (tick) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (abrir) restart = 1'b1;
        else if (cerrar && !alarma) state_d = ST_CLOSING;
        else if (tick && !alarma && !obstruccion) state_d = ST_CLOSING;
      end
      ST_CLOSING: begin
        if (abrir) begin
          state_d = ST_OPENING;
        end else if (obstruccion) begin
          if (reopen_q < MAX_R) begin
            reopen_d = reopen_q + 4'd1;
            state_d  = ST_OPENING;
          end else begin
            fault_d = 1'b1;
`ifdef PUERTA_NUDGE_EN
            state_d = ST_NUDGE;
`else
            state_d = ST_OPENING;
`endif
          end
        end else if (tick) begin
          state_d = ST_CLOSED;
        end
      end
`ifdef PUERTA_NUDGE_EN
      ST_NUDGE: begin
        if (abrir) state_d = ST_OPENING;
        else if (tick) state_d = ST_CLOSED;
      end
`endif
      default: state_d = ST_CLOSED;
    endcase

    entry = (state_d != state_q);

    // Returning to CLOSED finishes the cycle and clears per-cycle status.
    if (entry && state_d == ST_CLOSED) begin
      done_d    = cyc_act_q;
      cyc_act_d = 1'b0;
      reopen_d  = '0;
      fault_d   = 1'b0;
    end

    // Phase timer saturates at the exit count so an alarm hold keeps expiry.
    if (entry || restart || state_q == ST_CLOSED) timer_d = '0;
    else if (!tick) timer_d = timer_q + 1'b1;
    else timer_d = timer_q;

    blink_d = (state_d == ST_OPENING) || (state_d == ST_CLOSING);
`ifdef PUERTA_NUDGE_EN
    blink_d = blink_d || (state_d == ST_NUDGE);
`endif
    if (!blink_d) begin
      led_sw_d    = 1'b0;
      blink_cnt_d = '0;
    end else if (entry) begin
      led_sw_d    = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == CNT_W'(T_BLINK_HALF - 1)) begin
      led_sw_d    = ~led_sw_q;
      blink_cnt_d = '0;
    end else begin
      led_sw_d    = led_sw_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    case (state_d)
      ST_OPEN:    estado_d = 2'b00;
      ST_OPENING: estado_d = 2'b01;
      ST_CLOSED:  estado_d = 2'b11;
      default:    estado_d = 2'b10;
    endcase
    busy_d        = (state_d != ST_CLOSED);
    led_abierta_d = (state_d == ST_OPEN);
  end

  // State, counters and all outputs are registered with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_CLOSED;
      timer_q       <= '0;
      blink_cnt_q   <= '0;
      req_prev_q    <= 1'b0;
      cyc_act_q     <= 1'b0;
      reopen_q      <= '0;
      fault_q       <= 1'b0;
      estado_q      <= 2'b11;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      led_sw_q      <= 1'b0;
      led_abierta_q <= 1'b0;
      led_alarma_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      blink_cnt_q   <= blink_cnt_d;
      req_prev_q    <= cycle_req;
      cyc_act_q     <= cyc_act_d;
      reopen_q      <= reopen_d;
      fault_q       <= fault_d;
      estado_q      <= estado_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      led_sw_q      <= led_sw_d;
      led_abierta_q <= led_abierta_d;
      led_alarma_q  <= alarma;
    end
  end

  assign estado_puerta = estado_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign LED_sw        = led_sw_q;
  assign LED_abierta   = led_abierta_q;
  assign LED_alarma    = led_alarma_q;
  assign fault         = fault_q;
  assign reopen_cnt    = reopen_q;

endmodule

// File: tb/tb_puerta_ctrl_param.sv
// Directed bench for puerta_ctrl_param with small phase times
// (T_TRANS=4, T_OPEN=8, T_BLINK_HALF=2, MAX_REOPEN=2, T_NUDGE=6).
// Build with +define+PUERTA_NUDGE_EN to exercise the nudge variant.
module tb_puerta_ctrl_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       cycle_req, abrir, cerrar, obstruccion, alarma;
  logic [1:0] estado_puerta;
  logic       busy, done, LED_sw, LED_abierta, LED_alarma, fault;
  logic [3:0] reopen_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  puerta_ctrl_param #(
    .CNT_W(32), .T_TRANS(4), .T_OPEN(8), .T_BLINK_HALF(2),
    .MAX_REOPEN(2), .T_NUDGE(6)
  ) dut (
    .clk(clk), .rst(rst), .cycle_req(cycle_req), .abrir(abrir),
    .cerrar(cerrar), .obstruccion(obstruccion), .alarma(alarma),
    .estado_puerta(estado_puerta), .busy(busy), .done(done),
    .LED_sw(LED_sw), .LED_abierta(LED_abierta), .LED_alarma(LED_alarma),
    .fault(fault), .reopen_cnt(reopen_cnt)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps through n observations of one phase, starting at resident index
  // first. Blink LED expectation for half-period 2: 1,1,0,0,1,1,...
  task automatic phase(input logic [1:0] code, input int first, input int n, input string tag);
    for (int i = first; i < first + n; i++) begin
      step();
      check({tag, "_estado"}, estado_puerta, code);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_led_sw"}, LED_sw,
            (code == 2'b01 || code == 2'b10) ? 32'(((i / 2) % 2) == 0) : 32'd0);
      check({tag, "_led_abierta"}, LED_abierta, 32'(code == 2'b00));
    end
  endtask

  task automatic closing_done(input logic done_exp, input string tag);
    step();
    check({tag, "_closed"}, estado_puerta, 2'b11);
    check({tag, "_busy0"}, busy, 0);
    check({tag, "_done"}, done, done_exp);
    check({tag, "_reopen0"}, reopen_cnt, 0);
    check({tag, "_fault0"}, fault, 0);
    check({tag, "_led_sw0"}, LED_sw, 0);
    step();
    check({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; cycle_req = 1'b0; abrir = 1'b0; cerrar = 1'b0;
    obstruccion = 1'b0; alarma = 1'b0;
    step(); step();
    check("rst_estado", estado_puerta, 2'b11);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_led_sw", LED_sw, 0);
    check("rst_led_abierta", LED_abierta, 0);
    check("rst_led_alarma", LED_alarma, 0);
    check("rst_fault", fault, 0);
    check("rst_reopen", reopen_cnt, 0);
    rst = 1'b0;
    step();
    check("idle_estado", estado_puerta, 2'b11);

    // Basic cycle, request held high throughout.
    cycle_req = 1'b1;
    phase(2'b01, 0, 4, "c1_opening");
    phase(2'b00, 0, 8, "c1_open");
    phase(2'b10, 0, 4, "c1_closing");
    closing_done(1'b1, "c1");
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_no_restart", estado_puerta, 2'b11);
      check("hold_no_done", done, 0);
    end
    cycle_req = 1'b0;
    step();
    cycle_req = 1'b1;
    step();
    check("restart_estado", estado_puerta, 2'b01);
    phase(2'b01, 1, 3, "c2_opening");
    phase(2'b00, 0, 8, "c2_open");
    phase(2'b10, 0, 4, "c2_closing");
    closing_done(1'b1, "c2");
    cycle_req = 1'b0;

    // Manual-only cycle gives no done.
    abrir = 1'b1;
    step();
    check("man_estado", estado_puerta, 2'b01);
    abrir = 1'b0;
    phase(2'b01, 1, 3, "man_opening");
    phase(2'b00, 0, 8, "man_open");
    phase(2'b10, 0, 4, "man_closing");
    closing_done(1'b0, "man");

    // Obstruction reopens up to the limit.
    cycle_req = 1'b1;
    phase(2'b01, 0, 4, "ob_opening");
    phase(2'b00, 0, 8, "ob_open");
    for (int r = 1; r <= 2; r++) begin
      phase(2'b10, 0, 2, "ob_closing");
      obstruccion = 1'b1;
      step();
      obstruccion = 1'b0;
      check("ob_reopen_estado", estado_puerta, 2'b01);
      check("ob_reopen_cnt", reopen_cnt, r);
      check("ob_fault0", fault, 0);
      phase(2'b01, 1, 3, "ob_reopening");
      phase(2'b00, 0, 8, "ob_reopen_open");
    end
    phase(2'b10, 0, 2, "ob3_closing");
    obstruccion = 1'b1;
    step();
    obstruccion = 1'b0;
    check("ob3_fault", fault, 1);
    check("ob3_reopen_sat", reopen_cnt, 2);
`ifdef PUERTA_NUDGE_EN
    check("ob3_nudge_estado", estado_puerta, 2'b10);
    check("ob3_nudge_led", LED_sw, 1);
    phase(2'b10, 1, 5, "nudge");
    check("nudge_fault_held", fault, 1);
`else
    check("ob3_reopen_estado", estado_puerta, 2'b01);
    phase(2'b01, 1, 3, "ob3_opening");
    phase(2'b00, 0, 8, "ob3_open");
    phase(2'b10, 0, 4, "ob3_closing_done");
    check("ob3_fault_held", fault, 1);
`endif
    closing_done(1'b1, "ob_end");
    cycle_req = 1'b0;
    step();

    // Alarm holds the door open past dwell expiry.
    cycle_req = 1'b1;
    alarma = 1'b1;
    phase(2'b01, 0, 4, "al_opening");
    check("al_led_alarma", LED_alarma, 1);
    phase(2'b00, 0, 8, "al_open");
    phase(2'b00, 8, 5, "al_hold");
    check("al_hold_led_alarma", LED_alarma, 1);
    alarma = 1'b0;
    step();
    check("al_release_closing", estado_puerta, 2'b10);
    check("al_release_led_alarma", LED_alarma, 0);
    phase(2'b10, 1, 3, "al_closing");
    closing_done(1'b1, "al");
    cycle_req = 1'b0;
    step();

    // cerrar in OPEN, then abrir in CLOSING.
    cycle_req = 1'b1;
    phase(2'b01, 0, 4, "cc_opening");
    phase(2'b00, 0, 3, "cc_open");
    cerrar = 1'b1;
    step();
    cerrar = 1'b0;
    check("cc_cerrar_closing", estado_puerta, 2'b10);
    phase(2'b10, 1, 1, "cc_closing");
    abrir = 1'b1;
    step();
    abrir = 1'b0;
    check("cc_abrir_opening", estado_puerta, 2'b01);
    check("cc_abrir_reopen_cnt", reopen_cnt, 0);
    phase(2'b01, 1, 3, "cc_opening2");
    phase(2'b00, 0, 8, "cc_open2");
    phase(2'b10, 0, 4, "cc_closing2");
    closing_done(1'b1, "cc");
    cycle_req = 1'b0;
    step();

    // Simultaneous edge and abrir; abrir in OPEN restarts dwell.
    cycle_req = 1'b1;
    abrir = 1'b1;
    step();
    abrir = 1'b0;
    check("sim_estado", estado_puerta, 2'b01);
    phase(2'b01, 1, 3, "sim_opening");
    phase(2'b00, 0, 5, "sim_open");
    abrir = 1'b1;
    step();
    abrir = 1'b0;
    check("dwell_restart_estado", estado_puerta, 2'b00);
    phase(2'b00, 1, 7, "sim_open_restarted");
    phase(2'b10, 0, 4, "sim_closing");
    closing_done(1'b1, "sim");
    cycle_req = 1'b0;
    step();

    // Asynchronous reset mid-OPENING.
    cycle_req = 1'b1;
    alarma = 1'b1;
    phase(2'b01, 0, 2, "rs_opening");
    check("rs_led_alarma_pre", LED_alarma, 1);
    #2 rst = 1'b1;
    #1;
    check("rs_estado", estado_puerta, 2'b11);
    check("rs_busy", busy, 0);
    check("rs_led_sw", LED_sw, 0);
    check("rs_led_alarma", LED_alarma, 0);
    check("rs_done", done, 0);
    cycle_req = 1'b0;
    alarma = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rs_post_estado", estado_puerta, 2'b11);
      check("rs_post_done", done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
